// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package mult8_pkg;

  localparam int HI_W     = 5;
  localparam int LO_W     = 3;
  localparam int OP_W     = HI_W + LO_W;
  localparam int PP_W     = 2 * HI_W;
  localparam int SHIFT_HH = 6;
  localparam int SHIFT_X  = 3;
  localparam int PROD_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    HH,
    HL,
    LH,
    LL,
    DONE
  } state_t;

  function automatic logic [HI_W-1:0] hi_field(input logic [OP_W-1:0] v);
    return v[OP_W-1:LO_W];
  endfunction

  // Low field is zero-extended so it can share the 5x5 multiplier.
  function automatic logic [HI_W-1:0] lo_field(input logic [OP_W-1:0] v);
    return {{(HI_W-LO_W){1'b0}}, v[LO_W-1:0]};
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// rtl/mult8_seq_ctrl_if.sv - operand/product handshake bundle for mult8_seq_ctrl
interface mult8_seq_ctrl_if;
  import mult8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              drop_low;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] p;

  modport master (
    output in_valid, a, b, drop_low, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, drop_low, out_ready,
    output in_ready, out_valid, p
  );

endinterface

// File: rtl/mul5x5_core.sv
// rtl/mul5x5_core.sv - combinational unsigned 5x5 -> 10-bit multiplier core
module mul5x5_core
  import mult8_pkg::*;
(
  input  logic [HI_W-1:0] x,
  input  logic [HI_W-1:0] y,
  output logic [PP_W-1:0] prod
);

  assign prod = x * y;

endmodule

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 multiplier built from four sequential 5x5 partial products
module mult8_seq_ctrl
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mult8_seq_ctrl_if.slave   bus
);

  state_t            state;
  state_t            state_nxt;
  logic [OP_W-1:0]   a_r;
  logic [OP_W-1:0]   b_r;
  logic              drop_r;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_add;
  logic [PROD_W-1:0] pp_ext;
  logic [HI_W-1:0]   mul_x;
  logic [HI_W-1:0]   mul_y;
  logic [PP_W-1:0]   mul_p;
  logic              in_ready;
  logic              accept;

  mul5x5_core u_mul (
    .x    (mul_x),
    .y    (mul_y),
    .prod (mul_p)
  );

  assign pp_ext        = {{(PROD_W-PP_W){1'b0}}, mul_p};
  assign in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.p         = acc;

  always_comb begin
    state_nxt = state;
    mul_x     = '0;
    mul_y     = '0;
    acc_add   = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = HH;
      end
      HH: begin
        mul_x     = hi_field(a_r);
        mul_y     = hi_field(b_r);
        acc_add   = pp_ext << SHIFT_HH;
        state_nxt = HL;
      end
      HL: begin
        mul_x     = hi_field(a_r);
        mul_y     = lo_field(b_r);
        acc_add   = pp_ext << SHIFT_X;
        state_nxt = LH;
      end
      LH: begin
        mul_x     = lo_field(a_r);
        mul_y     = hi_field(b_r);
        acc_add   = pp_ext << SHIFT_X;
        state_nxt = drop_r ? DONE : LL;
      end
      LL: begin
        mul_x     = lo_field(a_r);
        mul_y     = lo_field(b_r);
        acc_add   = pp_ext;
        state_nxt = DONE;
      end
      DONE: begin
        // A consumer take and a new accept can share one edge.
        if (bus.out_ready) state_nxt = accept ? HH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      drop_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r    <= bus.a;
        b_r    <= bus.b;
        drop_r <= bus.drop_low;
        acc    <= '0;
      end else begin
        acc <= acc + acc_add;
      end
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - directed and randomized self-checking bench for mult8_seq_ctrl
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mult8_seq_ctrl_if bus ();

  mult8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b, input bit drop);
    int full;
    int low;
    full = int'(a) * int'(b);
    low  = int'(a % 8) * int'(b % 8);
    return drop ? 32'(full - low) : 32'(full);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The accept edge counts as edge 1; out_valid appears after edge 5 (edge 4 with drop_low).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit drop,
                        input int stall, input string tag);
    logic [31:0] exp;
    int          lat;
    exp = model(a, b, drop);
    lat = drop ? 4 : 5;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.drop_low  = drop;
    bus.out_ready = (stall == 0);
    #1;
    chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.drop_low = 1'($urandom);
    for (int k = 2; k < lat; k++) begin
      tick();
      chk({tag, "_valid_early"}, 32'(bus.out_valid), 32'd0);
    end
    tick();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_p"}, 32'(bus.p), exp);
    for (int s = 0; s < stall; s++) begin
      chk({tag, "_in_ready_stall"}, 32'(bus.in_ready), 32'd0);
      tick();
      chk({tag, "_valid_hold"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_p_hold"}, 32'(bus.p), exp);
    end
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd1);
    tick();
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'd5;
    bus.b         = 8'd5;
    bus.drop_low  = 1'b0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_p", 32'(bus.p), 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_no_accept", 32'(bus.out_valid), 32'd0);

    run_op(8'd255, 8'd255, 1'b0, 0, "max");
    run_op(8'd7, 8'd7, 1'b1, 0, "drop7");
    run_op(8'd7, 8'd7, 1'b0, 0, "full7");
    run_op(8'd200, 8'd3, 1'b0, 10, "stall");

    // Back-to-back: in_valid held, second accept in the DONE cycle of the first.
    bus.in_valid  = 1'b1;
    bus.a         = 8'd13;
    bus.b         = 8'd17;
    bus.drop_low  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.a = 8'd255;
    bus.b = 8'd1;
    for (int k = 2; k < 5; k++) begin
      tick();
      chk("b2b1_valid_early", 32'(bus.out_valid), 32'd0);
    end
    tick();
    chk("b2b1_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b1_p", 32'(bus.p), 32'd221);
    chk("b2b1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b2_no_bubble", 32'(bus.out_valid), 32'd0);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk("b2b2_valid_early", 32'(bus.out_valid), 32'd0);
    end
    tick();
    chk("b2b2_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b2_p", 32'(bus.p), 32'd255);
    tick();
    chk("b2b2_valid_drop", 32'(bus.out_valid), 32'd0);

    // Reset while in HL aborts the operation.
    bus.in_valid = 1'b1;
    bus.a        = 8'd100;
    bus.b        = 8'd50;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(8'd9, 8'd9, 1'b0, 0, "after_abort");

    for (int n = 0; n < 24; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult8_seq_ctrl.md
MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 SHALL declare port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL declare port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL declare port: in_valid  input  1  operand pair offered.
REQ-004 SHALL declare port: in_ready  output  1  block can accept operands.
REQ-005 SHALL declare port: a  input  8  multiplicand.
REQ-006 SHALL declare port: b  input  8  multiplier.
REQ-007 SHALL declare port: drop_low  input  1  skip the low*low partial product (approximate mode).
REQ-008 SHALL declare port: out_valid  output  1  product available.
REQ-009 SHALL declare port: out_ready  input  1  consumer takes product.
REQ-010 SHALL declare port: p  output  16  product.

Function
REQ-011 SHALL split operands into high field [7:3] (5 bit) and low field [2:0] (3 bit), zero-extending low fields to 5 bits before multiplication.
REQ-012 SHALL compute all partial products on one shared 5x5 multiplier, one partial product per cycle.
REQ-013 SHALL use FSM states IDLE, HH, HL, LH, LL, DONE.
REQ-014 SHALL accept on an edge where in_valid and in_ready are both 1, latching a, b and drop_low into internal registers and clearing a 16-bit accumulator.
REQ-015 SHALL ignore a, b and drop_low after acceptance until the next accept.
REQ-016 SHALL assert in_ready only in IDLE, or in DONE while out_ready is 1.
REQ-017 SHALL step through states in this order: HH (acc += AH*BH<<6), HL (acc += AH*BL<<3), LH (acc += AL*BH<<3), LL (acc += AL*BL), then DONE.
REQ-018 SHALL go from LH directly to DONE when the latched drop_low is 1.
REQ-019 SHALL assert out_valid exactly in DONE, with p = acc held stable while out_valid is 1.
REQ-020 SHALL set out_valid rising 5 edges after the accept edge, or 4 edges with drop_low.
REQ-021 SHALL hold DONE while out_ready is 0 (backpressure with no limit).
REQ-022 SHALL, in DONE with out_ready=1, go to IDLE, or go to HH with new operands latched if in_valid=1 (back-to-back, no bubble).
REQ-023 SHALL keep all arithmetic exact and unsigned; the maximum 255*255=65025 fits in 16 bits with no overflow handling.
REQ-024 SHALL drive the shared multiplier inputs to zero in IDLE and DONE.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, set the state to IDLE, acc and p to 0, out_valid to 0, and in_ready to 1 on the following cycle.
REQ-026 SHALL let reset during any compute state or DONE abort the operation and discard the product, with no out_valid afterwards.
REQ-027 SHALL ignore in_valid while rst_n=0.

Structure
REQ-028 SHALL place in shared package mult8_pkg: the FSM state enum, the split constants (HI_W=5, LO_W=3, SHIFT_HH=6, SHIFT_X=3) and the product width 16.
REQ-029 SHALL instantiate exactly one sub-module mul5x5_core (5x5 -> 10-bit, combinational), replaceable by an approximate variant with the same ports.
REQ-030 SHALL keep the FSM, operand registers and accumulator inside mult8_seq_ctrl.

Verification
REQ-031 SHALL cover: a=255, b=255, drop_low=0, out_ready=1 -> p=65025, out_valid high on 5th edge after accept, for one cycle.
REQ-032 SHALL cover: a=7, b=7, drop_low=1 -> p=0 after 4 edges; same operands with drop_low=0 -> p=49 after 5 edges.
REQ-033 SHALL cover: a=200, b=3, out_ready=0 for 10 cycles -> out_valid and p=600 held stable, in_ready=0, until out_ready rises.
REQ-034 SHALL cover: back-to-back pairs (13,17), (255,1) with in_valid held and out_ready=1 -> p=221 then 255, second accept in the DONE cycle of the first.
REQ-035 SHALL cover: rst_n=0 for one edge while in HL -> out_valid stays 0, in_ready=1 next cycle, next op (9,9) -> p=81.
REQ-036 SHALL cover: a or b changed mid-operation after accept -> result uses the latched values.
